// File: rtl/result_bus_arbiter.sv
// Round-robin arbiter granting up to two completed results per cycle onto the
// reorder buffer's two registered result buses.
`ifndef ROB_WIDTH_BIT
`define ROB_WIDTH_BIT 4
`endif

module result_bus_arbiter #(
  parameter int unsigned NREQ          = 4,
  parameter int unsigned ROB_WIDTH_BIT = `ROB_WIDTH_BIT
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          rdy_in,
  input  logic                          clear,
  input  logic [NREQ-1:0]               req_valid,
  input  logic [NREQ*ROB_WIDTH_BIT-1:0] req_rob_id,
  input  logic [NREQ*32-1:0]            req_value,
  output logic [NREQ-1:0]               req_ready,
  output logic                          out0_ready,
  output logic [ROB_WIDTH_BIT-1:0]      out0_rob_id,
  output logic [31:0]                   out0_value,
  output logic                          out1_ready,
  output logic [ROB_WIDTH_BIT-1:0]      out1_rob_id,
  output logic [31:0]                   out1_value,
  output logic                          err_dup
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]            rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]            scan_idx;
  logic [PW-1:0]            grant_a, grant_b;
  logic                     grant_a_vld, grant_b_vld;
  logic [ROB_WIDTH_BIT-1:0] a_id, b_id;
  logic [31:0]              a_val, b_val;
  logic                     active, dup;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    if (int'(p) == int'(NREQ) - 1) return '0;
    return p + 1'b1;
  endfunction

  // Walk the ring once from rr_ptr; first two valid requesters win.
  always_comb begin
    grant_a_vld = 1'b0;
    grant_b_vld = 1'b0;
    grant_a     = '0;
    grant_b     = '0;
    scan_idx    = rr_ptr_q;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (req_valid[scan_idx]) begin
        if (!grant_a_vld) begin
          grant_a_vld = 1'b1;
          grant_a     = scan_idx;
        end else if (!grant_b_vld) begin
          grant_b_vld = 1'b1;
          grant_b     = scan_idx;
        end
      end
      scan_idx = wrap_inc(scan_idx);
    end
  end

  always_comb begin
    a_id  = req_rob_id[int'(grant_a)*ROB_WIDTH_BIT +: ROB_WIDTH_BIT];
    b_id  = req_rob_id[int'(grant_b)*ROB_WIDTH_BIT +: ROB_WIDTH_BIT];
    a_val = req_value[int'(grant_a)*32 +: 32];
    b_val = req_value[int'(grant_b)*32 +: 32];
    dup   = grant_a_vld && grant_b_vld && (a_id == b_id);
  end

  assign active = rst_in && !clear && rdy_in;

  always_comb begin
    req_ready = '0;
    if (active) begin
      if (grant_a_vld) req_ready[grant_a] = 1'b1;
      if (grant_b_vld) req_ready[grant_b] = 1'b1;
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_b_vld)      rr_ptr_d = wrap_inc(grant_b);
    else if (grant_a_vld) rr_ptr_d = wrap_inc(grant_a);
  end

  // Stalled cycles (rdy_in low) hold every register, so a live bus stays up.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      rr_ptr_q    <= '0;
      out0_ready  <= 1'b0;
      out0_rob_id <= '0;
      out0_value  <= '0;
      out1_ready  <= 1'b0;
      out1_rob_id <= '0;
      out1_value  <= '0;
      err_dup     <= 1'b0;
    end else if (clear) begin
      rr_ptr_q   <= '0;
      out0_ready <= 1'b0;
      out1_ready <= 1'b0;
    end else if (rdy_in) begin
      rr_ptr_q   <= rr_ptr_d;
      out0_ready <= grant_a_vld;
      out1_ready <= grant_b_vld;
      if (grant_a_vld) begin
        out0_rob_id <= a_id;
        out0_value  <= a_val;
      end
      if (grant_b_vld) begin
        out1_rob_id <= b_id;
        out1_value  <= b_val;
      end
      if (dup) err_dup <= 1'b1;
    end
  end

endmodule

// File: tb/tb_result_bus_arbiter.sv
// Vector table with hand-picked grants; a bus model feeds a scoreboard queue
// that is checked one edge later, followed by a fairness sweep.
module tb_result_bus_arbiter;

  localparam int NREQ = 4;
  localparam int RW   = 4;

  logic              clk_in = 1'b0;
  logic              rst_in, rdy_in, clear;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*RW-1:0] req_rob_id;
  logic [NREQ*32-1:0] req_value;
  logic [NREQ-1:0]   req_ready;
  logic              out0_ready, out1_ready, err_dup;
  logic [RW-1:0]     out0_rob_id, out1_rob_id;
  logic [31:0]       out0_value, out1_value;

  result_bus_arbiter #(.NREQ(NREQ), .ROB_WIDTH_BIT(RW)) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .rdy_in      (rdy_in),
    .clear       (clear),
    .req_valid   (req_valid),
    .req_rob_id  (req_rob_id),
    .req_value   (req_value),
    .req_ready   (req_ready),
    .out0_ready  (out0_ready),
    .out0_rob_id (out0_rob_id),
    .out0_value  (out0_value),
    .out1_ready  (out1_ready),
    .out1_rob_id (out1_rob_id),
    .out1_value  (out1_value),
    .err_dup     (err_dup)
  );

  always #5 clk_in = ~clk_in;

  // Requester r carries value vbase ^ r; a/b are the expected grants (-1 = none).
  typedef struct {
    bit          rst, clr, rdy;
    logic [3:0]  valid;
    logic [15:0] ids;
    logic [31:0] vbase;
    int          a, b;
  } vec_t;

  typedef struct {
    logic        r0, r1, err;
    logic [3:0]  id0, id1;
    logic [31:0] v0, v1;
  } bus_t;

  vec_t tbl[$];
  bus_t sb[$];
  bus_t model, got;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void add(bit rst, bit clr, bit rdy, logic [3:0] valid,
                              logic [15:0] ids, logic [31:0] vbase, int a, int b);
    vec_t v;
    v.rst = rst; v.clr = clr; v.rdy = rdy; v.valid = valid;
    v.ids = ids; v.vbase = vbase; v.a = a; v.b = b;
    tbl.push_back(v);
  endfunction

  task automatic drive(input vec_t v);
    rst_in     = v.rst;
    clear      = v.clr;
    rdy_in     = v.rdy;
    req_valid  = v.valid;
    req_rob_id = v.ids;
    for (int r = 0; r < NREQ; r++) req_value[r*32 +: 32] = v.vbase ^ 32'(r);
  endtask

  initial begin
    vec_t v;
    logic [3:0] exp_rr;
    int since [NREQ];

    rst_in = 1'b0; clear = 1'b0; rdy_in = 1'b1;
    req_valid = '0; req_rob_id = '0; req_value = '0;
    model = '{default: '0};

    // reset held with all requests valid
    add(0, 0, 1, 4'b1111, 16'h7531, 32'hDEADBEED, -1, -1);
    add(0, 0, 1, 4'b1111, 16'h7531, 32'hDEADBEED, -1, -1);
    add(0, 0, 1, 4'b1111, 16'h7531, 32'hDEADBEED, -1, -1);
    // round robin, all valid (req 2: id 5, value DEADBEEF)
    add(1, 0, 1, 4'b1111, 16'h7531, 32'hDEADBEED,  0,  1);
    add(1, 0, 1, 4'b1111, 16'h7531, 32'hDEADBEED,  2,  3);
    add(1, 0, 1, 4'b1111, 16'h7531, 32'hDEADBEED,  0,  1);
    add(1, 0, 1, 4'b1111, 16'h7531, 32'hDEADBEED,  2,  3);
    // single requester 3 (id 7, value 0x1234), then 0 and 3
    add(1, 0, 1, 4'b1000, 16'h7000, 32'h00001237,  3, -1);
    add(1, 0, 1, 4'b1001, 16'h2001, 32'h00000100,  0,  3);
    // grant then clear with req 1 still valid
    add(1, 0, 1, 4'b0010, 16'h0040, 32'h00000200,  1, -1);
    add(1, 1, 1, 4'b0010, 16'h0040, 32'h00000200, -1, -1);
    add(1, 0, 1, 4'b1111, 16'hABCD, 32'h00000300,  0,  1);
    // grant then three stall cycles
    add(1, 0, 1, 4'b0100, 16'h0E00, 32'h00000400,  2, -1);
    add(1, 0, 0, 4'b0100, 16'h0E00, 32'h00000400, -1, -1);
    add(1, 0, 0, 4'b0100, 16'h0E00, 32'h00000400, -1, -1);
    add(1, 0, 0, 4'b0100, 16'h0E00, 32'h00000400, -1, -1);
    add(1, 0, 1, 4'b0000, 16'h0E00, 32'h00000400, -1, -1);
    // duplicate id 9 on req 0 and 2 (pointer is at 3), then clear
    add(1, 0, 1, 4'b0101, 16'h0909, 32'h00000500,  0,  2);
    add(1, 1, 1, 4'b0000, 16'h0000, 32'h00000000, -1, -1);
    // stall, then clear arriving while still stalled
    add(1, 0, 1, 4'b0001, 16'h0001, 32'h00000000,  0, -1);
    add(1, 0, 0, 4'b0000, 16'h0001, 32'h00000000, -1, -1);
    add(1, 1, 0, 4'b0000, 16'h0001, 32'h00000000, -1, -1);
    add(1, 0, 1, 4'b0110, 16'h0120, 32'h00000600,  1,  2);
    // reset together with clear mid-operation
    add(0, 1, 1, 4'b1111, 16'h7531, 32'h00000700, -1, -1);
    add(1, 0, 1, 4'b1111, 16'h7531, 32'h00000700,  0,  1);

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      @(negedge clk_in);
      drive(v);
      #1;
      exp_rr = '0;
      if (v.a >= 0) exp_rr[v.a] = 1'b1;
      if (v.b >= 0) exp_rr[v.b] = 1'b1;
      chk($sformatf("req_ready[%0d]", i), 64'(req_ready), 64'(exp_rr));

      if (!v.rst) begin
        model = '{default: '0};
      end else if (v.clr) begin
        model.r0 = 1'b0;
        model.r1 = 1'b0;
      end else if (v.rdy) begin
        model.r0 = (v.a >= 0);
        model.r1 = (v.b >= 0);
        if (v.a >= 0) begin
          model.id0 = v.ids[v.a*4 +: 4];
          model.v0  = v.vbase ^ 32'(v.a);
        end
        if (v.b >= 0) begin
          model.id1 = v.ids[v.b*4 +: 4];
          model.v1  = v.vbase ^ 32'(v.b);
          if (v.ids[v.a*4 +: 4] == v.ids[v.b*4 +: 4]) model.err = 1'b1;
        end
      end
      sb.push_back(model);

      @(posedge clk_in);
      #1;
      got = sb.pop_front();
      chk($sformatf("bus0[%0d]", i), 64'({out0_ready, out0_rob_id, out0_value}),
          64'({got.r0, got.id0, got.v0}));
      chk($sformatf("bus1[%0d]", i), 64'({out1_ready, out1_rob_id, out1_value}),
          64'({got.r1, got.id1, got.v1}));
      chk($sformatf("err_dup[%0d]", i), 64'(err_dup), 64'(got.err));
    end

    // Fairness: with everyone valid, no requester waits two cycles.
    for (int r = 0; r < NREQ; r++) since[r] = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_in);
      rst_in = 1'b1; clear = 1'b0; rdy_in = 1'b1; req_valid = 4'b1111;
      #1;
      chk($sformatf("grant_count[%0d]", c), 64'($countones(req_ready)), 64'd2);
      for (int r = 0; r < NREQ; r++) begin
        if (req_ready[r]) since[r] = 0;
        else since[r]++;
        chk($sformatf("fair_req%0d[%0d]", r, c), 64'(since[r] < 2), 64'd1);
      end
    end

    @(negedge clk_in);
    req_valid = '0;
    @(posedge clk_in);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
